// File: rtl/dma_pkg.sv
// Shared constants for the OAM / CGB VRAM DMA engine: transfer lengths,
// snooped register addresses, bus base addresses and the FSM state type.
// Optional feature macro: DMA_HBLANK_EN adds the H-blank DMA wait state.
package dma_pkg;

    localparam int unsigned OAM_LEN   = 160;
    localparam int unsigned BLOCK_LEN = 16;
    localparam int unsigned START_DLY = 4;

    localparam int unsigned IDX_W = 8;
    localparam int unsigned BLK_W = 4;
    localparam int unsigned DLY_W = 3;
    localparam int unsigned LEN_W = 7;

    localparam logic [15:0] REG_OAM   = 16'hFF46;
    localparam logic [15:0] REG_HDMA1 = 16'hFF51;
    localparam logic [15:0] REG_HDMA2 = 16'hFF52;
    localparam logic [15:0] REG_HDMA3 = 16'hFF53;
    localparam logic [15:0] REG_HDMA4 = 16'hFF54;
    localparam logic [15:0] REG_HDMA5 = 16'hFF55;

    localparam logic [15:0] OAM_BASE  = 16'hFE00;
    localparam logic [15:0] VRAM_BASE = 16'h8000;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_OAM_WAIT,
        ST_OAM_RD,
        ST_OAM_WR,
        ST_V_START,
        ST_V_RD,
        ST_V_WR,
        ST_V_DONE
`ifdef DMA_HBLANK_EN
        , ST_H_WAIT
`endif
    } dma_state_e;

    // Full VRAM address from the 13-bit destination offset.
    function automatic logic [15:0] vram_addr(input logic [12:0] off);
        return {VRAM_BASE[15:13], off};
    endfunction

endpackage

// File: rtl/dma_regs.sv
// VRAM DMA register file: snoops CPU writes to FF51-FF55, holds source,
// destination and block count, tracks active/cancelled state, and produces
// the FF55 read value.
// Ports: clk4_2/reset_n; cpu_addr/cpu_wdata/cpu_we snoop; src_step/dst_step/
// block_done from the engine FSM; src/dst/len/active/hdma_mode to the FSM;
// hdma5_rdata (registered FF55 read value).
// Macro DMA_HBLANK_EN enables FF55 bit7 (H-blank arm / cancel).
module dma_regs
    import dma_pkg::*;
(
    input  logic             clk4_2,
    input  logic             reset_n,
    input  logic [15:0]      cpu_addr,
    input  logic [7:0]       cpu_wdata,
    input  logic             cpu_we,
    input  logic             src_step,
    input  logic             dst_step,
    input  logic             block_done,
    output logic [15:0]      src,
    output logic [15:0]      dst,
    output logic [LEN_W-1:0] len,
    output logic             active,
    output logic             hdma_mode,
    output logic [7:0]       hdma5_rdata
);

    logic [12:0]      dst_off, dst_off_n;
    logic [15:0]      src_n;
    logic [LEN_W-1:0] len_n;
    logic             active_n, hdma_n, cancel, cancel_n;
    logic [7:0]       hdma5_n;

    assign dst = vram_addr(dst_off);

    // Next-state for all registers; CPU writes take priority over FSM updates.
    always_comb begin
        src_n     = src;
        dst_off_n = dst_off;
        len_n     = len;
        active_n  = active;
        hdma_n    = hdma_mode;
        cancel_n  = cancel;

        if (src_step) src_n = src + 16'd1;
        if (dst_step) dst_off_n = dst_off + 13'd1;
        if (block_done) begin
            len_n = len - LEN_W'(1);
            if (len == '0) begin
                active_n = 1'b0;
                hdma_n   = 1'b0;
                cancel_n = 1'b0;
            end
        end

        if (cpu_we) begin
            case (cpu_addr)
                REG_HDMA1: src_n[15:8]      = cpu_wdata;
                REG_HDMA2: src_n[7:0]       = {cpu_wdata[7:4], 4'h0};
                REG_HDMA3: dst_off_n[12:8]  = cpu_wdata[4:0];
                REG_HDMA4: dst_off_n[7:0]   = {cpu_wdata[7:4], 4'h0};
                REG_HDMA5: begin
`ifdef DMA_HBLANK_EN
                    if (cpu_wdata[7]) begin
                        len_n    = cpu_wdata[6:0];
                        active_n = 1'b1;
                        hdma_n   = 1'b1;
                        cancel_n = 1'b0;
                    end else if (active && hdma_mode) begin
                        // Cancel: the block in flight still completes.
                        active_n = 1'b0;
                        hdma_n   = 1'b0;
                        cancel_n = 1'b1;
                    end else begin
                        len_n    = cpu_wdata[6:0];
                        active_n = 1'b1;
                        hdma_n   = 1'b0;
                        cancel_n = 1'b0;
                    end
`else
                    len_n    = cpu_wdata[6:0];
                    active_n = 1'b1;
                    cancel_n = 1'b0;
`endif
                end
                default: ;
            endcase
        end

        if (active_n)      hdma5_n = {1'b0, len_n};
        else if (cancel_n) hdma5_n = {1'b1, len_n};
        else               hdma5_n = 8'hFF;
    end

    always_ff @(posedge clk4_2 or negedge reset_n) begin
        if (!reset_n) begin
            src         <= '0;
            dst_off     <= '0;
            len         <= '0;
            active      <= 1'b0;
            hdma_mode   <= 1'b0;
            cancel      <= 1'b0;
            hdma5_rdata <= 8'hFF;
        end else begin
            src         <= src_n;
            dst_off     <= dst_off_n;
            len         <= len_n;
            active      <= active_n;
            hdma_mode   <= hdma_n;
            cancel      <= cancel_n;
            hdma5_rdata <= hdma5_n;
        end
    end

endmodule

// File: rtl/dma_engine.sv
// OAM DMA (FF46) and CGB VRAM DMA (FF51-FF55) engine. Owns the memory bus
// while transferring: one byte per two clocks (read cycle, write cycle).
// Ports: clk4_2/reset_n; cpu_addr/cpu_wdata/cpu_we register snoop;
// mem_rdata read return; hblank_start/lcd_on from the PPU; dma_addr/
// dma_wdata/dma_we/dma_bus_own bus drive; oam_dma_busy; DMA_start/
// GDMA_finished stall handshake to cpu_top; hdma5_rdata FF55 read value.
// Macro DMA_HBLANK_EN enables H-blank DMA (H_WAIT state).
module dma_engine
    import dma_pkg::*;
(
    input  logic        clk4_2,
    input  logic        reset_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic [7:0]  mem_rdata,
    input  logic        hblank_start,
    input  logic        lcd_on,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_wdata,
    output logic        dma_we,
    output logic        dma_bus_own,
    output logic        oam_dma_busy,
    output logic        DMA_start,
    output logic        GDMA_finished,
    output logic [7:0]  hdma5_rdata
);

    dma_state_e       state;
    logic [7:0]       oam_hi;
    logic             oam_pend;
    logic [IDX_W-1:0] idx;
    logic [BLK_W-1:0] vidx;
    logic [DLY_W-1:0] dly;

    logic [15:0]      src, dst;
    logic [LEN_W-1:0] len;
    logic             v_active, hdma_mode;

    logic oam_wr_c, oam_state_c, idle_like_c, oam_go_c;
    logic src_step_c, dst_step_c, block_done_c, v_last_c;

    dma_regs u_regs (
        .clk4_2      (clk4_2),
        .reset_n     (reset_n),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_we      (cpu_we),
        .src_step    (src_step_c),
        .dst_step    (dst_step_c),
        .block_done  (block_done_c),
        .src         (src),
        .dst         (dst),
        .len         (len),
        .active      (v_active),
        .hdma_mode   (hdma_mode),
        .hdma5_rdata (hdma5_rdata)
    );

    assign oam_wr_c    = cpu_we && (cpu_addr == REG_OAM);
    assign oam_state_c = (state == ST_OAM_WAIT) || (state == ST_OAM_RD) || (state == ST_OAM_WR);
`ifdef DMA_HBLANK_EN
    assign idle_like_c = (state == ST_IDLE) || (state == ST_H_WAIT);
`else
    assign idle_like_c = (state == ST_IDLE);
    logic unused_hblank;
    assign unused_hblank = &{1'b0, hblank_start, lcd_on, hdma_mode};
`endif
    // OAM DMA may (re)start only when no VRAM block is on the bus.
    assign oam_go_c = (oam_wr_c && (idle_like_c || oam_state_c)) || (oam_pend && idle_like_c);

    // Source steps after each read, destination after each write, so the
    // address registered on entry to the next phase is already current.
    assign src_step_c   = (state == ST_V_RD);
    assign dst_step_c   = (state == ST_V_WR);
    assign block_done_c = (state == ST_V_DONE);
    assign v_last_c     = !v_active || (len == '0);

    always_ff @(posedge clk4_2 or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            oam_hi        <= '0;
            oam_pend      <= 1'b0;
            idx           <= '0;
            vidx          <= '0;
            dly           <= '0;
            dma_addr      <= '0;
            dma_wdata     <= '0;
            dma_we        <= 1'b0;
            dma_bus_own   <= 1'b0;
            oam_dma_busy  <= 1'b0;
            DMA_start     <= 1'b0;
            GDMA_finished <= 1'b0;
        end else begin
            dma_addr      <= '0;
            dma_wdata     <= '0;
            dma_we        <= 1'b0;
            dma_bus_own   <= 1'b0;
            DMA_start     <= 1'b0;
            GDMA_finished <= 1'b0;

            if (oam_wr_c) oam_hi <= cpu_wdata;
            if (oam_wr_c && !oam_go_c) oam_pend <= 1'b1;

            if (oam_go_c) begin
                state        <= ST_OAM_WAIT;
                dly          <= DLY_W'(START_DLY - 1);
                idx          <= '0;
                oam_pend     <= 1'b0;
                oam_dma_busy <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (v_active) begin
`ifdef DMA_HBLANK_EN
                            if (hdma_mode) begin
                                state <= ST_H_WAIT;
                            end else begin
                                state     <= ST_V_START;
                                DMA_start <= 1'b1;
                            end
`else
                            state     <= ST_V_START;
                            DMA_start <= 1'b1;
`endif
                        end
                    end
                    ST_OAM_WAIT: begin
                        if (dly == '0) begin
                            state       <= ST_OAM_RD;
                            dma_addr    <= {oam_hi, idx};
                            dma_bus_own <= 1'b1;
                        end else begin
                            dly <= dly - DLY_W'(1);
                        end
                    end
                    ST_OAM_RD: begin
                        state       <= ST_OAM_WR;
                        dma_addr    <= {OAM_BASE[15:8], idx};
                        dma_wdata   <= mem_rdata;
                        dma_we      <= 1'b1;
                        dma_bus_own <= 1'b1;
                    end
                    ST_OAM_WR: begin
                        if (idx == IDX_W'(OAM_LEN - 1)) begin
                            state        <= ST_IDLE;
                            oam_dma_busy <= 1'b0;
                        end else begin
                            idx         <= idx + IDX_W'(1);
                            state       <= ST_OAM_RD;
                            dma_addr    <= {oam_hi, idx + IDX_W'(1)};
                            dma_bus_own <= 1'b1;
                        end
                    end
                    ST_V_START: begin
                        state       <= ST_V_RD;
                        vidx        <= '0;
                        dma_addr    <= src;
                        dma_bus_own <= 1'b1;
                    end
                    ST_V_RD: begin
                        state       <= ST_V_WR;
                        dma_addr    <= dst;
                        dma_wdata   <= mem_rdata;
                        dma_we      <= 1'b1;
                        dma_bus_own <= 1'b1;
                    end
                    ST_V_WR: begin
                        if (vidx == BLK_W'(BLOCK_LEN - 1)) begin
                            state         <= ST_V_DONE;
                            GDMA_finished <= 1'b1;
                        end else begin
                            vidx        <= vidx + BLK_W'(1);
                            state       <= ST_V_RD;
                            dma_addr    <= src;
                            dma_bus_own <= 1'b1;
                        end
                    end
                    ST_V_DONE: begin
                        if (v_last_c) begin
                            state <= ST_IDLE;
                        end else begin
`ifdef DMA_HBLANK_EN
                            if (hdma_mode) begin
                                state <= ST_H_WAIT;
                            end else begin
                                state     <= ST_V_START;
                                DMA_start <= 1'b1;
                            end
`else
                            state     <= ST_V_START;
                            DMA_start <= 1'b1;
`endif
                        end
                    end
`ifdef DMA_HBLANK_EN
                    ST_H_WAIT: begin
                        // With the LCD off there is no H-blank to wait for.
                        if (!v_active) begin
                            state <= ST_IDLE;
                        end else if (hblank_start || !lcd_on) begin
                            state     <= ST_V_START;
                            DMA_start <= 1'b1;
                        end
                    end
`endif
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dma_engine.sv
// Directed self-checking bench for dma_engine: OAM DMA timing and data,
// FF46 restart, GDMA addressing and FF55 readback, source/destination wrap,
// OAM/VRAM arbitration, reset mid-transfer, and (with DMA_HBLANK_EN) H-blank
// DMA including cancel. Memory returns addr[7:0]^addr[15:8] for any read.
module tb_dma_engine;

    logic        clk4_2 = 1'b0;
    logic        reset_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic [7:0]  mem_rdata;
    logic        hblank_start;
    logic        lcd_on;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_we;
    logic        dma_bus_own;
    logic        oam_dma_busy;
    logic        DMA_start;
    logic        GDMA_finished;
    logic [7:0]  hdma5_rdata;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic seen_a, seen_b;
    int   n_wait;

    always #5 clk4_2 = ~clk4_2;

    dma_engine dut (
        .clk4_2        (clk4_2),
        .reset_n       (reset_n),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_we        (cpu_we),
        .mem_rdata     (mem_rdata),
        .hblank_start  (hblank_start),
        .lcd_on        (lcd_on),
        .dma_addr      (dma_addr),
        .dma_wdata     (dma_wdata),
        .dma_we        (dma_we),
        .dma_bus_own   (dma_bus_own),
        .oam_dma_busy  (oam_dma_busy),
        .DMA_start     (DMA_start),
        .GDMA_finished (GDMA_finished),
        .hdma5_rdata   (hdma5_rdata)
    );

    always_comb mem_rdata = dma_addr[7:0] ^ dma_addr[15:8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk4_2);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = 1'b1;
        tick();
        cpu_we    = 1'b0;
    endtask

    // Called at the V_START cycle; checks one 16-byte block through V_DONE.
    task automatic vblock(input logic [15:0] s, input logic [15:0] d);
        logic [15:0] sa, da;
        check("v_start", 32'(DMA_start), 32'(1'b1));
        for (int j = 0; j < 16; j++) begin
            sa = s + 16'(j);
            da = {3'b100, 13'(d[12:0] + 13'(j))};
            tick();
            check("v_rd", 32'({dma_bus_own, dma_we, dma_addr}), 32'({1'b1, 1'b0, sa}));
            tick();
            check("v_wr", 32'({dma_bus_own, dma_we, dma_addr, dma_wdata}),
                  32'({1'b1, 1'b1, da, sa[7:0] ^ sa[15:8]}));
        end
        tick();
        check("v_done", 32'({GDMA_finished, dma_bus_own}), 32'({1'b1, 1'b0}));
    endtask

    initial begin
        logic [7:0] kk;
        reset_n      = 1'b0;
        cpu_addr     = '0;
        cpu_wdata    = '0;
        cpu_we       = 1'b0;
        hblank_start = 1'b0;
        lcd_on       = 1'b1;
        #12;
        check("rst_bus", 32'({dma_addr, dma_wdata, dma_we, dma_bus_own}), 32'h0);
        check("rst_flags", 32'({oam_dma_busy, DMA_start, GDMA_finished}), 32'h0);
        check("rst_hdma5", 32'(hdma5_rdata), 32'hFF);
        reset_n = 1'b1;
        tick();

        // OAM DMA from C100: 4-clock delay then 160 read/write pairs.
        wr(16'hFF46, 8'hC1);
        check("oam_busy_set", 32'({oam_dma_busy, dma_bus_own}), 32'({1'b1, 1'b0}));
        repeat (3) tick();
        check("oam_delay", 32'(dma_bus_own), 32'h0);
        for (int k = 0; k < 160; k++) begin
            kk = 8'(k);
            tick();
            check("oam_rd", 32'({dma_bus_own, dma_we, dma_addr}), 32'({1'b1, 1'b0, 8'hC1, kk}));
            tick();
            check("oam_wr", 32'({dma_bus_own, dma_we, dma_addr, dma_wdata, oam_dma_busy}),
                  32'({1'b1, 1'b1, 8'hFE, kk, kk ^ 8'hC1, 1'b1}));
        end
        tick();
        check("oam_end", 32'({oam_dma_busy, dma_bus_own}), 32'h0);

        // FF46 write during OAM DMA restarts it from the new page.
        wr(16'hFF46, 8'hC1);
        repeat (5) tick();
        wr(16'hFF46, 8'hC3);
        check("restart_busy", 32'({oam_dma_busy, dma_bus_own}), 32'({1'b1, 1'b0}));
        repeat (3) tick();
        check("restart_delay", 32'(dma_bus_own), 32'h0);
        tick();
        check("restart_rd", 32'({dma_bus_own, dma_addr}), 32'({1'b1, 16'hC300}));
        tick();
        check("restart_wr", 32'({dma_we, dma_addr, dma_wdata}), 32'({1'b1, 16'hFE00, 8'hC3}));
        n_wait = 0;
        while (oam_dma_busy && n_wait < 400) begin
            tick();
            n_wait++;
        end
        check("restart_len", 32'(n_wait), 32'd319);

        // GDMA, 2 blocks D000 -> 8120.
        wr(16'hFF51, 8'hD0);
        wr(16'hFF52, 8'h0F);
        wr(16'hFF53, 8'h01);
        wr(16'hFF54, 8'h20);
        wr(16'hFF55, 8'h01);
        check("gdma_hdma5_arm", 32'(hdma5_rdata), 32'h01);
        tick();
        vblock(16'hD000, 16'h8120);
        tick();
        check("gdma_hdma5_mid", 32'(hdma5_rdata), 32'h00);
        vblock(16'hD010, 16'h8130);
        tick();
        check("gdma_end", 32'({hdma5_rdata, dma_bus_own, DMA_start}), 32'({8'hFF, 1'b0, 1'b0}));

        // Source wrap FFFF->0000 and destination wrap 9FFF->8000.
        wr(16'hFF51, 8'hFF);
        wr(16'hFF52, 8'hF0);
        wr(16'hFF53, 8'h1F);
        wr(16'hFF54, 8'hF0);
        wr(16'hFF55, 8'h01);
        tick();
        vblock(16'hFFF0, 16'h9FF0);
        tick();
        vblock(16'h0000, 16'h8000);
        tick();
        check("wrap_end", 32'(hdma5_rdata), 32'hFF);

        // GDMA requested during OAM DMA waits for the last OAM write.
        wr(16'hFF51, 8'hC4);
        wr(16'hFF52, 8'h00);
        wr(16'hFF53, 8'h02);
        wr(16'hFF54, 8'h00);
        wr(16'hFF46, 8'hC5);
        wr(16'hFF55, 8'h00);
        seen_a = 1'b0;
        for (int c = 2; c <= 323; c++) begin
            tick();
            seen_a = seen_a | DMA_start;
        end
        check("held_no_vstart", 32'({seen_a, oam_dma_busy}), 32'({1'b0, 1'b1}));
        tick();
        check("held_oam_done", 32'({oam_dma_busy, DMA_start}), 32'h0);
        tick();
        vblock(16'hC400, 16'h8200);
        tick();
        check("held_end", 32'(hdma5_rdata), 32'hFF);

        // Reset mid-GDMA: back to idle, no finished pulse.
        wr(16'hFF55, 8'h03);
        repeat (10) tick();
        reset_n = 1'b0;
        #2;
        check("rst_mid_bus", 32'({dma_addr, dma_we, dma_bus_own, DMA_start}), 32'h0);
        check("rst_mid_hdma5", 32'(hdma5_rdata), 32'hFF);
        #2;
        reset_n = 1'b1;
        seen_a = 1'b0;
        seen_b = 1'b0;
        for (int c = 0; c < 80; c++) begin
            tick();
            seen_a = seen_a | GDMA_finished;
            seen_b = seen_b | dma_bus_own | DMA_start;
        end
        check("rst_mid_quiet", 32'({seen_a, seen_b}), 32'h0);

`ifdef DMA_HBLANK_EN
        // H-blank DMA: one block per hblank_start, then cancel.
        wr(16'hFF51, 8'hC0);
        wr(16'hFF52, 8'h00);
        wr(16'hFF53, 8'h00);
        wr(16'hFF54, 8'h00);
        wr(16'hFF55, 8'h82);
        check("hdma_arm", 32'(hdma5_rdata), 32'h02);
        repeat (5) tick();
        check("hdma_wait", 32'({dma_bus_own, DMA_start}), 32'h0);
        hblank_start = 1'b1;
        tick();
        hblank_start = 1'b0;
        vblock(16'hC000, 16'h8000);
        tick();
        check("hdma_after1", 32'({hdma5_rdata, dma_bus_own}), 32'({8'h01, 1'b0}));
        repeat (3) tick();
        check("hdma_idle1", 32'(DMA_start), 32'h0);
        hblank_start = 1'b1;
        tick();
        hblank_start = 1'b0;
        vblock(16'hC010, 16'h8010);
        tick();
        check("hdma_after2", 32'(hdma5_rdata), 32'h00);
        wr(16'hFF55, 8'h00);
        check("hdma_cancel", 32'(hdma5_rdata), 32'h80);
        tick();
        hblank_start = 1'b1;
        tick();
        hblank_start = 1'b0;
        check("hdma_cancel_nostart", 32'(DMA_start), 32'h0);
        repeat (3) tick();
        check("hdma_cancel_idle", 32'({dma_bus_own, hdma5_rdata}), 32'({1'b0, 8'h80}));
`else
        // Without H-blank support, bit7 is ignored and FF55=80 is a 1-block GDMA.
        wr(16'hFF51, 8'h12);
        wr(16'hFF55, 8'h80);
        check("bit7_gdma_arm", 32'(hdma5_rdata), 32'h00);
        tick();
        vblock(16'h1200, 16'h8000);
        tick();
        check("bit7_gdma_end", 32'({hdma5_rdata, dma_bus_own}), 32'({8'hFF, 1'b0}));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
